// File: rtl/hms_alarm_clock.sv
// rtl/hms_alarm_clock.sv - hour:min:sec timekeeper with N hour:min alarm slots and ring FSM
// Optional snooze state enabled by defining SNOOZE_EN.
module hms_alarm_clock #(
    parameter int N_ALARM    = 4,
    parameter int SLOT_W     = 2,
    parameter int HOUR_MAX   = 23,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_mode_btn,
    input  logic               i_pos_btn,
    input  logic               i_inc_btn,
    input  logic               i_alarm_btn,
    input  logic [SLOT_W-1:0]  i_slot,
    output logic [1:0]         o_mode,
    output logic [1:0]         o_position,
    output logic [4:0]         o_hour,
    output logic [5:0]         o_min,
    output logic [5:0]         o_sec,
    output logic               o_day_pulse,
    output logic [N_ALARM-1:0] o_alarm_en,
    output logic               o_alarm,
    output logic [SLOT_W-1:0]  o_alarm_slot
);
    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} ring_st_t;
    localparam logic [1:0] MODE_CLOCK = 2'd0, MODE_SETUP = 2'd1, MODE_ALARM = 2'd2;
    localparam logic [1:0] POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2;

    logic [5:0]         sec_q, sec_d, min_q, min_d;
    logic [4:0]         hour_q, hour_d;
    logic [1:0]         mode_q, mode_d, pos_q, pos_d;
    logic [4:0]         al_hour_q [N_ALARM];
    logic [4:0]         al_hour_d [N_ALARM];
    logic [5:0]         al_min_q  [N_ALARM];
    logic [5:0]         al_min_d  [N_ALARM];
    logic [N_ALARM-1:0] alarm_en_q, alarm_en_d;
    ring_st_t           st_q, st_d;
    logic [9:0]         cnt_q, cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               day_q, day_d;

    logic advance, sec_wrap, min_wrap, hour_wrap, slot_ok;
    logic pos_go, inc_go, alm_go, enter_setup, snooze_take, edit_inc, abort_ring;
    logic match_hit;
    logic [SLOT_W-1:0] match_idx;

    always_comb begin
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        mode_d     = mode_q;
        pos_d      = pos_q;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        alarm_en_d = alarm_en_q;
        st_d       = st_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;

        advance   = i_tick && (mode_q != MODE_SETUP);
        sec_wrap  = (sec_q == 6'd59);
        min_wrap  = (min_q == 6'd59);
        hour_wrap = (hour_q == 5'(HOUR_MAX));
        slot_ok   = (int'(i_slot) < N_ALARM);

        // The mode button swallows every other button in the same cycle.
        pos_go      = i_pos_btn && !i_mode_btn;
        inc_go      = i_inc_btn && !i_mode_btn;
        alm_go      = i_alarm_btn && !i_mode_btn;
        enter_setup = i_mode_btn && (mode_q == MODE_CLOCK);
`ifdef SNOOZE_EN
        snooze_take = inc_go && (st_q == ST_RING);
`else
        snooze_take = 1'b0;
`endif
        edit_inc = inc_go && !snooze_take;

        if (advance) begin
            sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
            if (sec_wrap) min_d = min_wrap ? 6'd0 : min_q + 6'd1;
            if (sec_wrap && min_wrap) hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
        end
        day_d = advance && sec_wrap && min_wrap && hour_wrap;

        // Match against the post-tick time; descending scan lets the lowest slot win.
        match_hit = 1'b0;
        match_idx = '0;
        if (advance && sec_wrap) begin
            for (int i = N_ALARM - 1; i >= 0; i--) begin
                if (alarm_en_q[i] && al_hour_q[i] == hour_d && al_min_q[i] == min_d) begin
                    match_hit = 1'b1;
                    match_idx = SLOT_W'(i);
                end
            end
        end

        if (i_mode_btn) begin
            mode_d = (mode_q == MODE_ALARM) ? MODE_CLOCK : mode_q + 2'd1;
            pos_d  = POS_SEC;
        end else if (pos_go) begin
            pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
        end

        if (edit_inc && mode_q == MODE_SETUP) begin
            case (pos_q)
                POS_SEC:  sec_d  = sec_wrap ? 6'd0 : sec_q + 6'd1;
                POS_MIN:  min_d  = min_wrap ? 6'd0 : min_q + 6'd1;
                POS_HOUR: hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
                default: ;
            endcase
        end

        for (int i = 0; i < N_ALARM; i++) begin
            if (slot_ok && SLOT_W'(i) == i_slot && mode_q == MODE_ALARM) begin
                if (edit_inc && pos_q == POS_MIN)
                    al_min_d[i] = (al_min_q[i] == 6'd59) ? 6'd0 : al_min_q[i] + 6'd1;
                if (edit_inc && pos_q == POS_HOUR)
                    al_hour_d[i] = (al_hour_q[i] == 5'(HOUR_MAX)) ? 5'd0 : al_hour_q[i] + 5'd1;
                if (alm_go && st_q == ST_IDLE)
                    alarm_en_d[i] = ~alarm_en_q[i];
            end
        end

        abort_ring = enter_setup || alm_go || !alarm_en_q[slot_q];
        case (st_q)
            ST_IDLE: begin
                if (match_hit) begin
                    st_d   = ST_RING;
                    cnt_d  = 10'(RING_SEC);
                    slot_d = match_idx;
                end
            end
            ST_RING: begin
                if (abort_ring) begin
                    st_d = ST_IDLE;
                end else if (snooze_take) begin
                    st_d  = ST_SNOOZE;
                    cnt_d = 10'(SNOOZE_SEC);
                end else if (i_tick) begin
                    if (cnt_q <= 10'd1) st_d = ST_IDLE;
                    else cnt_d = cnt_q - 10'd1;
                end
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
                if (abort_ring) begin
                    st_d = ST_IDLE;
                end else if (i_tick) begin
                    if (cnt_q <= 10'd1) begin
                        st_d  = ST_RING;
                        cnt_d = 10'(RING_SEC);
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
            end
`endif
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            mode_q     <= MODE_CLOCK;
            pos_q      <= POS_SEC;
            for (int i = 0; i < N_ALARM; i++) begin
                al_hour_q[i] <= '0;
                al_min_q[i]  <= '0;
            end
            alarm_en_q <= '0;
            st_q       <= ST_IDLE;
            cnt_q      <= '0;
            slot_q     <= '0;
            day_q      <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            alarm_en_q <= alarm_en_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            day_q      <= day_d;
        end
    end

    always_comb begin
        o_hour = hour_q;
        o_min  = min_q;
        o_sec  = sec_q;
        if (mode_q == MODE_ALARM) begin
            o_hour = '0;
            o_min  = '0;
            o_sec  = '0;
            for (int i = 0; i < N_ALARM; i++) begin
                if (slot_ok && SLOT_W'(i) == i_slot) begin
                    o_hour = al_hour_q[i];
                    o_min  = al_min_q[i];
                end
            end
        end
    end

    assign o_mode       = mode_q;
    assign o_position   = pos_q;
    assign o_day_pulse  = day_q;
    assign o_alarm_en   = alarm_en_q;
    assign o_alarm      = (st_q == ST_RING);
    assign o_alarm_slot = slot_q;
endmodule

// File: tb/tb_hms_alarm_clock.sv
// tb/tb_hms_alarm_clock.sv - randomized + directed bench for hms_alarm_clock against a seconds-of-day model
module tb_hms_alarm_clock;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int HM = 23;
    localparam int RS = 5;
    localparam int SS = 3;

    logic clk = 1'b0;
    logic rst_n, tick, mode_btn, pos_btn, inc_btn, alarm_btn;
    logic [SW-1:0] slot;
    logic [1:0] o_mode, o_position;
    logic [4:0] o_hour;
    logic [5:0] o_min, o_sec;
    logic o_day_pulse, o_alarm;
    logic [N-1:0] o_alarm_en;
    logic [SW-1:0] o_alarm_slot;

    hms_alarm_clock #(.N_ALARM(N), .SLOT_W(SW), .HOUR_MAX(HM), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_mode_btn(mode_btn), .i_pos_btn(pos_btn),
        .i_inc_btn(inc_btn), .i_alarm_btn(alarm_btn), .i_slot(slot), .o_mode(o_mode),
        .o_position(o_position), .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
        .o_day_pulse(o_day_pulse), .o_alarm_en(o_alarm_en), .o_alarm(o_alarm),
        .o_alarm_slot(o_alarm_slot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_on = 0;

    // Model: time as seconds-of-day, alarms as minute-of-day, ring state 0=idle 1=ring 2=snooze.
    int m_t, m_mode, m_pos, m_st, m_cnt, m_slot;
    int m_amin [N];
    bit [N-1:0] m_en;
    bit m_day;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nt, h, mi, s, n_st, n_cnt, n_slot, idx;
        bit adv, hit, mb, pb, ib, ab, snz, ent_setup;
        if (!rst_n) begin
            m_t = 0; m_mode = 0; m_pos = 0; m_st = 0; m_cnt = 0; m_slot = 0;
            m_en = '0; m_day = 0;
            for (int i = 0; i < N; i++) m_amin[i] = 0;
            return;
        end
        adv = tick && m_mode != 1;
        nt  = adv ? (m_t + 1) % ((HM + 1) * 3600) : m_t;
        m_day = adv && nt == 0;
        hit = 0; idx = 0;
        if (adv && nt % 60 == 0)
            for (int i = N - 1; i >= 0; i--)
                if (m_en[i] && m_amin[i] == nt / 60) begin hit = 1; idx = i; end
        mb = mode_btn; pb = pos_btn && !mb; ib = inc_btn && !mb; ab = alarm_btn && !mb;
        ent_setup = mb && m_mode == 0;
        snz = 0;
`ifdef SNOOZE_EN
        snz = ib && m_st == 1;
`endif
        n_st = m_st; n_cnt = m_cnt; n_slot = m_slot;
        if (m_st == 0) begin
            if (hit) begin n_st = 1; n_cnt = RS; n_slot = idx; end
        end else if (ent_setup || ab || !m_en[m_slot]) begin
            n_st = 0;
        end else if (m_st == 1 && snz) begin
            n_st = 2; n_cnt = SS;
        end else if (tick) begin
            if (m_cnt == 1) begin
                n_st = (m_st == 2) ? 1 : 0;
                if (m_st == 2) n_cnt = RS;
            end else n_cnt = m_cnt - 1;
        end
        if (ib && !snz && m_mode == 1) begin
            h = nt / 3600; mi = (nt / 60) % 60; s = nt % 60;
            if (m_pos == 0) s = (s + 1) % 60;
            if (m_pos == 1) mi = (mi + 1) % 60;
            if (m_pos == 2) h = (h + 1) % (HM + 1);
            nt = h * 3600 + mi * 60 + s;
        end
        if (m_mode == 2 && int'(slot) < N) begin
            h = m_amin[slot] / 60; mi = m_amin[slot] % 60;
            if (ib && !snz && m_pos == 1) mi = (mi + 1) % 60;
            if (ib && !snz && m_pos == 2) h = (h + 1) % (HM + 1);
            m_amin[slot] = h * 60 + mi;
            if (ab && m_st == 0) m_en[slot] = ~m_en[slot];
        end
        if (mb) begin m_mode = (m_mode + 1) % 3; m_pos = 0; end
        else if (pb) m_pos = (m_pos + 1) % 3;
        m_t = nt; m_st = n_st; m_cnt = n_cnt; m_slot = n_slot;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int eh, em, es;
            if (m_mode == 2) begin eh = m_amin[slot] / 60; em = m_amin[slot] % 60; es = 0; end
            else begin eh = m_t / 3600; em = (m_t / 60) % 60; es = m_t % 60; end
            chk("mode", o_mode, m_mode);
            chk("position", o_position, m_pos);
            chk("hour", o_hour, eh);
            chk("min", o_min, em);
            chk("sec", o_sec, es);
            chk("day_pulse", o_day_pulse, m_day);
            chk("alarm_en", o_alarm_en, m_en);
            chk("alarm", o_alarm, m_st == 1);
            chk("alarm_slot", o_alarm_slot, m_slot);
        end
    end

    task automatic cyc(input bit t, input bit m, input bit p, input bit i, input bit a);
        tick = t; mode_btn = m; pos_btn = p; inc_btn = i; alarm_btn = a;
        @(posedge clk);
        model_step();
        #2;
        tick = 0; mode_btn = 0; pos_btn = 0; inc_btn = 0; alarm_btn = 0;
    endtask

    task automatic tick_n(input int n);  for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0); endtask
    task automatic inc_n(input int n);   for (int k = 0; k < n; k++) cyc(0, 0, 0, 1, 0); endtask
    task automatic press_mode();  cyc(0, 1, 0, 0, 0); endtask
    task automatic press_pos();   cyc(0, 0, 1, 0, 0); endtask
    task automatic press_alarm(); cyc(0, 0, 0, 0, 1); endtask

    initial begin
        rst_n = 0; slot = '0;
        tick = 0; mode_btn = 0; pos_btn = 0; inc_btn = 0; alarm_btn = 0;
        #2;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst_n = 1;
        chk_on = 1;
        chk("lit_reset_mode", o_mode, 0);
        chk("lit_reset_alarm", o_alarm, 0);
        chk("lit_reset_en", o_alarm_en, 0);

        tick_n(3661);
        chk("lit_3661_hour", o_hour, 1);
        chk("lit_3661_min", o_min, 1);
        chk("lit_3661_sec", o_sec, 1);

        press_mode(); inc_n(58); press_pos(); inc_n(58); press_pos(); inc_n(22);
        tick_n(3);
        chk("lit_setup_frozen_sec", o_sec, 59);
        chk("lit_setup_hour", o_hour, 23);
        press_mode(); press_mode();
        cyc(1, 0, 0, 0, 0);
        chk("lit_wrap_hour", o_hour, 0);
        chk("lit_wrap_sec", o_sec, 0);
        chk("lit_day_pulse_hi", o_day_pulse, 1);
        cyc(0, 0, 0, 0, 0);
        chk("lit_day_pulse_lo", o_day_pulse, 0);

        press_mode(); press_mode(); press_pos();
        slot = 1; inc_n(30); slot = 3; inc_n(30);
        press_pos();
        slot = 1; inc_n(7); slot = 3; inc_n(7);
        slot = 1; press_alarm(); slot = 3; press_alarm();
        chk("lit_en_1010", o_alarm_en, 4'b1010);
        chk("lit_slot3_min", o_min, 30);
        press_mode(); press_mode();
        inc_n(59); press_pos(); inc_n(29); press_pos(); inc_n(7);
        press_mode(); press_mode();
        cyc(1, 0, 0, 0, 0);
        chk("lit_ring_on", o_alarm, 1);
        chk("lit_ring_slot1", o_alarm_slot, 1);
        tick_n(4);
        chk("lit_ring_still", o_alarm, 1);
        cyc(1, 0, 0, 0, 0);
        chk("lit_ring_timeout", o_alarm, 0);

        press_mode(); press_mode(); slot = 0;
        press_pos(); inc_n(31); press_pos(); inc_n(7); press_alarm();
        press_mode();
        tick_n(55);
        chk("lit_ring_slot0", o_alarm_slot, 0);
        chk("lit_ring_on2", o_alarm, 1);
        press_alarm();
        chk("lit_stop_btn", o_alarm, 0);
        chk("lit_stop_en_kept", o_alarm_en, 4'b1011);

        press_mode(); press_mode(); press_alarm(); press_pos(); inc_n(1);
        press_mode();
        tick_n(60);
        chk("lit_disabled_no_ring", o_alarm, 0);
        chk("lit_0732_min", o_min, 32);

        cyc(0, 1, 0, 1, 0);
        chk("lit_mode_prio_mode", o_mode, 1);
        chk("lit_mode_prio_sec", o_sec, 0);
        cyc(0, 1, 0, 1, 0);
        press_mode();
        chk("lit_mode_prio_sec2", o_sec, 0);

        press_mode(); press_mode(); slot = 2;
        press_pos(); inc_n(33); press_pos(); inc_n(7); press_alarm();
        press_mode();
        tick_n(60);
        chk("lit_ring_slot2", o_alarm_slot, 2);
        cyc(0, 0, 0, 1, 0);
`ifdef SNOOZE_EN
        chk("lit_snooze_off", o_alarm, 0);
        tick_n(2);
        chk("lit_snooze_wait", o_alarm, 0);
        cyc(1, 0, 0, 0, 0);
        chk("lit_snooze_rering", o_alarm, 1);
        chk("lit_snooze_slot", o_alarm_slot, 2);
`else
        chk("lit_inc_keeps_ring", o_alarm, 1);
`endif
        rst_n = 0;
        cyc(0, 0, 0, 0, 0);
        rst_n = 1;
        chk("lit_rst_alarm", o_alarm, 0);
        chk("lit_rst_en", o_alarm_en, 0);
        chk("lit_rst_slot", o_alarm_slot, 0);
        chk("lit_rst_min", o_min, 0);

        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(15) == 0) slot = SW'($urandom_range(N - 1));
            rst_n = ($urandom_range(999) != 0);
            cyc($urandom_range(2) == 0, $urandom_range(39) == 0, $urandom_range(7) == 0,
                $urandom_range(3) == 0, $urandom_range(9) == 0);
            rst_n = 1;
        end

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
